// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: FSM state encoding and parameter defaults shared by
// fifo_read_ctrl and its optional stall timer.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int unsigned DATA_SIZE_DEF      = 8;
  localparam int unsigned LEN_SIZE_DEF       = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned TIMER_W            = 16;

endpackage

// File: rtl/fifo_ctrl_timer.sv
// fifo_ctrl_timer: counts consecutive stall cycles and flags the cycle on
// which the limit-th stall is seen. Clears whenever the stall is broken.
module fifo_ctrl_timer
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned limit = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  output logic expired_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = '0;
    if (stall_i) begin
      count_d = (count_q == '1) ? count_q : count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = stall_i && (count_q == TIMER_W'(limit - 1));

endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: drains burst_len_i bytes from a FIFO into a valid/ready byte
// stream. Empty-stall timeout is built only with FIFO_READ_CTRL_TIMEOUT_EN.
module fifo_read_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned data_size      = DATA_SIZE_DEF,
  parameter int unsigned len_size       = LEN_SIZE_DEF,
  parameter int unsigned timeout_cycles = TIMEOUT_CYCLES_DEF
) (
  input  logic                 read_clock_i,
  input  logic                 read_reset_i,
  input  logic                 start_i,
  input  logic [len_size-1:0]  burst_len_i,
  input  logic                 abort_i,
  input  logic [data_size-1:0] fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_read_inc_o,
  output logic [data_size-1:0] byte_data_o,
  output logic                 byte_valid_o,
  input  logic                 byte_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  if (timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_timeout
    $error("fifo_read_ctrl: timeout_cycles must be within 1..65535");
  end

  state_e               state_q, state_d;
  logic [len_size-1:0]  remaining_q, remaining_d;
  logic [data_size-1:0] byte_q, byte_d;
  logic                 pop;
  logic                 timeout;

`ifdef FIFO_READ_CTRL_TIMEOUT_EN
  logic error_q;

  fifo_ctrl_timer #(
    .limit(timeout_cycles)
  ) u_timer (
    .clk_i    (read_clock_i),
    .rst_i    (read_reset_i),
    .stall_i  (state_q == FETCH && fifo_empty_i),
    .expired_o(timeout)
  );

  // Sticky until the next accepted start; an abort wins over a timeout.
  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      error_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      error_q <= 1'b0;
    end else if (state_q == FETCH && !abort_i && fifo_empty_i && timeout) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    byte_d      = byte_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          remaining_d = burst_len_i;
          state_d     = (burst_len_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (abort_i) begin
          state_d = DONE;
        end else if (!fifo_empty_i) begin
          pop     = 1'b1;
          byte_d  = fifo_data_i;
          state_d = PRESENT;
        end else if (timeout) begin
          state_d = DONE;
        end
      end
      PRESENT: begin
        if (abort_i) begin
          state_d = DONE;
        end else if (byte_ready_i) begin
          remaining_d = (remaining_q != '0) ? remaining_q - len_size'(1) : '0;
          state_d     = (remaining_d == '0) ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      byte_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      byte_q      <= byte_d;
    end
  end

  assign fifo_read_inc_o = pop && !read_reset_i;
  assign byte_data_o     = byte_q;
  assign byte_valid_o    = (state_q == PRESENT);
  assign busy_o          = (state_q == FETCH) || (state_q == PRESENT);
  assign done_o          = (state_q == DONE);

endmodule
